// File: rtl/onehot_enc_6to4_pkg.sv
// Shared constants and helpers for the 6-line event encoder.
// Codes 0..5 map one-to-one onto request lines; the idle code is zero.
package enc_pkg;

  localparam int N_LINES = 6;
  localparam int CODE_W  = 4;

  localparam logic [CODE_W-1:0] CODE_IDLE = '0;

  // Round-robin successor of a line index, wrapping 5 -> 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/onehot_enc_6to4_if.sv
// Code stream handshake: the encoder drives code/code_valid, the consumer drives code_ready.
// A code transfers on every rising edge where code_valid and code_ready are both high.
interface onehot_enc_6to4_if;
  import enc_pkg::*;

  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);

endinterface

// File: rtl/onehot_enc_6to4_rr_pick6.sv
// Combinational round-robin picker over six pending bits.
// Returns the first set bit at or above ptr, wrapping 5 -> 0.
module rr_pick6
  import enc_pkg::*;
(
  input  logic [N_LINES-1:0] pending,
  input  logic [2:0]         ptr,
  output logic               any,
  output logic [2:0]         idx,
  output logic [N_LINES-1:0] grant_mask
);

  logic [3:0] pos;

  always_comb begin
    any = 1'b0;
    idx = 3'd0;
    pos = 4'd0;
    for (int i = 0; i < N_LINES; i++) begin
      pos = {1'b0, ptr} + 4'(i);
      if (pos >= 4'd6) pos = pos - 4'd6;
      if (!any && pending[pos[2:0]]) begin
        any = 1'b1;
        idx = pos[2:0];
      end
    end
  end

  assign grant_mask = any ? (N_LINES'(1) << idx) : '0;

endmodule

// File: rtl/onehot_enc_6to4.sv
// Six-line event encoder: sticky pending bits, round-robin grant, one code per handshake.
// Merged re-requests raise the sticky ovf flag; pending is exported for debug.
module onehot_enc_6to4
  import enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_LINES-1:0]   req,
  input  logic                 clr_ovf,
  output logic [N_LINES-1:0]   pending,
  output logic                 ovf,
  onehot_enc_6to4_if.master    bus
);

  logic [2:0]         ptr;
  logic               pick_any;
  logic [2:0]         pick_idx;
  logic [N_LINES-1:0] pick_mask;

  logic               slot_free;
  logic               grant;
  logic [N_LINES-1:0] clear_mask;
  logic [N_LINES-1:0] pending_next;
  logic               ovf_set;

  rr_pick6 u_pick (
    .pending    (pending),
    .ptr        (ptr),
    .any        (pick_any),
    .idx        (pick_idx),
    .grant_mask (pick_mask)
  );

  // Slot is free when empty or being drained this cycle.
  always_comb begin
    slot_free    = !bus.code_valid || bus.code_ready;
    grant        = slot_free && en && pick_any;
    clear_mask   = grant ? pick_mask : '0;
    pending_next = pending;
    ovf_set      = 1'b0;
    if (en) begin
      pending_next = (pending & ~clear_mask) | req;
      // A re-request on the bit being granted is a fresh event, not an overflow.
      ovf_set      = |(req & pending & ~clear_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= '0;
      ptr            <= 3'd0;
      ovf            <= 1'b0;
      bus.code       <= CODE_IDLE;
      bus.code_valid <= 1'b0;
    end else begin
      pending <= pending_next;
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (grant) ptr <= wrap_inc(pick_idx);
      if (slot_free) begin
        if (grant) begin
          bus.code       <= {1'b0, pick_idx};
          bus.code_valid <= 1'b1;
        end else begin
          bus.code       <= CODE_IDLE;
          bus.code_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_onehot_enc_6to4.sv
// Bench for onehot_enc_6to4: directed scenarios with literal expectations plus an
// event-level model compared against the DUT on every negative clock edge.
module tb_onehot_enc_6to4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [5:0] req = '0;
  logic       clr_ovf = 1'b0;
  logic [5:0] pending;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  onehot_enc_6to4_if bus();

  onehot_enc_6to4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .clr_ovf (clr_ovf),
    .pending (pending),
    .ovf     (ovf),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_pend[6];
  int         m_ptr;
  bit         m_valid;
  int         m_code;
  bit         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_pend[n]) m_pend[n] = 0;
      m_ptr = 0; m_valid = 0; m_code = 0; m_ovf = 0;
    end else begin
      int  won;
      bit  free;
      bit  ovf_now;
      won = -1;
      ovf_now = 0;
      free = !m_valid || bus.code_ready;
      if (free && en)
        for (int k = 0; k < 6; k++)
          if (won < 0 && m_pend[(m_ptr + k) % 6]) won = (m_ptr + k) % 6;
      if (en)
        for (int n = 0; n < 6; n++) begin
          if (req[n] && m_pend[n] && n != won) ovf_now = 1;
          m_pend[n] = (m_pend[n] && n != won) || req[n];
        end
      if (ovf_now) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (free) begin
        m_valid = (won >= 0);
        m_code  = (won >= 0) ? won : 0;
      end
      if (won >= 0) m_ptr = (won + 1) % 6;
    end
  end

  function automatic int model_pending();
    int v = 0;
    for (int n = 0; n < 6; n++) if (m_pend[n]) v += (1 << n);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [5:0] dec;
      chk("model_code_valid", int'(bus.code_valid), int'(m_valid));
      chk("model_code", int'(bus.code), m_code);
      chk("model_pending", int'(pending), model_pending());
      chk("model_ovf", int'(ovf), int'(m_ovf));
      if (bus.code_valid) begin
        // 4-to-6 decoder loopback: a valid code selects exactly one line
        dec = (bus.code < 4'd6) ? (6'd1 << bus.code) : 6'd0;
        chk("code_in_range", int'(bus.code <= 4'd5), 1);
        chk("loopback_onehot", int'($countones(dec) == 1), 1);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; en = 1'b1; clr_ovf = 1'b0; bus.code_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic out_is(input string name, input int v, input int c);
    chk({name, "_valid"}, int'(bus.code_valid), v);
    chk({name, "_code"}, int'(bus.code), c);
  endtask

  initial begin
    bus.code_ready = 1'b0;
    do_reset();
    out_is("reset", 0, 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_ovf", int'(ovf), 0);

    // single event, then show ptr moved to 3
    bus.code_ready = 1'b1; req = 6'b000100; step();
    chk("single_pend", int'(pending), 6'b000100);
    chk("single_not_yet", int'(bus.code_valid), 0);
    req = '0; step();
    out_is("single", 1, 2);
    chk("single_drained", int'(pending), 0);
    step(); out_is("single_idle", 0, 0);
    req = 6'b001001; step(); req = '0;
    step(); out_is("ptr3_first", 1, 3);
    step(); out_is("ptr3_wrap", 1, 0);
    step(); out_is("ptr3_idle", 0, 0);

    // round robin from ptr 0
    do_reset();
    bus.code_ready = 1'b1; req = 6'b111111; step(); req = '0;
    for (int i = 0; i < 6; i++) begin step(); out_is("rr", 1, i); end
    step(); out_is("rr_end", 0, 0);

    // backpressure
    do_reset();
    req = 6'b010010; step(); req = '0;
    step(); out_is("bp_first", 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(); out_is("bp_hold", 1, 1);
      chk("bp_pend", int'(pending), 6'b010000);
    end
    bus.code_ready = 1'b1;
    step(); out_is("bp_second", 1, 4);
    step(); out_is("bp_end", 0, 0);

    // overflow: slot occupied by code 0, bit 3 requested twice
    do_reset();
    req = 6'b000001; step(); req = '0;
    step(); out_is("ovf_slot", 1, 0);
    req = 6'b001000; step(); req = '0; step();
    chk("ovf_before", int'(ovf), 0);
    req = 6'b001000; step(); req = '0;
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_pend", int'(pending), 6'b001000);
    bus.code_ready = 1'b1;
    step(); out_is("ovf_code3", 1, 3);
    step(); out_is("ovf_only_one", 0, 0);
    chk("ovf_sticky", int'(ovf), 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);

    // re-request in grant cycle: second code 3, no overflow
    req = 6'b001000; step(); step(); req = '0;
    out_is("same_first", 1, 3);
    chk("same_pend", int'(pending), 6'b001000);
    step(); out_is("same_second", 1, 3);
    step(); out_is("same_end", 0, 0);
    chk("same_no_ovf", int'(ovf), 0);

    // en low: requests ignored
    do_reset();
    bus.code_ready = 1'b1; en = 1'b0; req = 6'b111111; step();
    chk("en_pend", int'(pending), 0);
    en = 1'b1; req = '0; step();
    out_is("en_idle", 0, 0);

    // asynchronous reset mid-stream
    do_reset();
    req = 6'b101101; step(); req = '0; step();
    chk("mid_pend", int'(pending), 6'b101100);
    #2 rst_n = 1'b0; #1;
    out_is("mid_rst", 0, 0);
    chk("mid_rst_pend", int'(pending), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    step(); rst_n = 1'b1;
    step(); step(); out_is("post_rst", 0, 0);

    // random loopback traffic, checked by the model comparison
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      bus.code_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 9) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      step();
    end
    req = '0; en = 1'b1; clr_ovf = 1'b0; bus.code_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    out_is("drain", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_enc_6to4.md
# onehot_enc_6to4

Event encoder that converts six one-hot/multi-hot request lines into a stream of 4-bit line codes, one per handshake. It is the counterpart of the team's 4-to-6 line decoder: every code it emits (0–5) decodes back to exactly one request line. It sits between line-level event sources and any consumer that wants a compact index stream. It holds requests in sticky pending bits, arbitrates round-robin and presents one code at a time on a valid/ready interface.

## Interface
- `N_LINES`, default 6: request lines; fixed at 6 for this block.
- `CODE_W`, default 4: code width; matches the decoder input width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: when low, capture and grant are frozen; the output still drains.
- `req` in 6: request pulses or levels; bit n requests code n.
- `clr_ovf` in 1: synchronous clear of `ovf`.
- `code` out 4: line index 0–5; 4'b0000 when not valid.
- `code_valid` out 1: `code` is valid.
- `code_ready` in 1: consumer accepts `code` when high together with `code_valid`.
- `pending` out 6: current sticky pending vector, for debug.
- `ovf` out 1: sticky flag; a request was merged into an already-pending bit.

## Operation
- Reset values: `pending`=0, `code`=4'b0000, `code_valid`=0, `ovf`=0, round-robin pointer `ptr`=0.
- Capture (when `en`=1): `pending_next = (pending & ~grant_mask) | req`.
  - A `req` bit that is already pending and not being granted this cycle sets `ovf`. The event is merged, not queued.
- Grant: the output slot is free when `code_valid`=0 or (`code_valid` & `code_ready`).
  - If the slot is free, `en`=1 and `pending`≠0, pick the first set bit of `pending` searching upward from `ptr`, wrapping 5→0.
  - Load `code` with that index and set `code_valid`=1.
  - Clear that pending bit; `grant_mask` is one-hot at that index.
  - Set `ptr` = (index+1) mod 6.
- Slot free but no grant (`pending`=0 or `en`=0): `code_valid`→0 and `code`→0.
- Same-cycle set/clear: if `req` bit n is high in the cycle that bit n is granted, bit n stays pending. This is a new event and does not set `ovf`.
- `en`=0: `req` is ignored, `pending` and `ptr` hold, no new grant. A code already valid waits for `code_ready`.
- Output stability: `code` and `code_valid` are registered and hold steady while `code_valid`=1 and `code_ready`=0.
- `clr_ovf`: clears `ovf` on the next edge. If an overflow occurs in the same cycle, the set wins.
- Codes 6–15 are never emitted.
- Reset mid-operation: all state returns to its reset value immediately, because reset is asynchronous. In-flight pending bits are lost.

## Timing
- Latency: a `req` bit sampled at edge k sets `pending` after edge k. Grant happens at edge k+1, so `code_valid` is high after edge k+1. That is 2 edges, given a free slot and no competing bits.
- Throughput: one code per cycle while `code_ready`=1 and `pending`≠0.
- Back-to-back grants: the picker reads the registered `pending` and `ptr`. A bit cleared at edge k is not eligible again before edge k+1 unless it is re-requested.
- Fairness: with all 6 bits continuously pending, codes are emitted 0,1,2,3,4,5,0,… Any line waits at most 5 grants.

## Structure
- Package `enc_pkg`:
  - `N_LINES`=6 and `CODE_W`=4.
  - Code idle value 4'b0000.
  - Function `wrap_inc(idx)` returning (idx+1) mod 6.
- Sub-module `rr_pick6`, purely combinational:
  - Inputs: `pending`[5:0] and `ptr`[2:0].
  - Outputs: `any`, `idx`[2:0] and `grant_mask`[5:0].
- Top level holds the `pending`, `ptr`, output and `ovf` registers.

## Test plan
- Reset: hold `rst_n`=0 mid-stream with pending=6'b101101 → all outputs are 0 immediately. After release with no req, `code_valid` stays 0.
- Single event: `req`=6'b000100 for one cycle, `code_ready`=1 → `code`=2 with `code_valid` high 2 edges later. `pending` returns to 0 and `ptr`=3.
- Round-robin: `req`=6'b111111 for one cycle, `code_ready`=1 → codes 0,1,2,3,4,5 on consecutive cycles, then `code_valid`=0.
- Backpressure: `req`=6'b010010, `code_ready`=0 for 5 cycles → `code`=1 held stable. After ready rises: 1, then 4.
- Overflow and same-cycle set/clear:
  - Pulse `req` bit 3 twice while `code_ready`=0 → `ovf`=1 and only one code 3 is emitted.
  - `clr_ovf` → `ovf`=0.
  - A `req` on bit 3 in its grant cycle → a second code 3 with `ovf` unchanged.
- Loopback: feed `code` into the 4-to-6 decoder with `en`=`code_valid` under random `req` → decoder output is always one-hot and equals the granted line. No code is ever >5.
